// File: rtl/extract_pivot_col.sv
// Pulls the pivot-column element and the RHS element out of every tableau row
// streamed in row-major order; optional POSITIVE_FILTER_EN flags positive pivots.
module extract_pivot_col #(
    parameter int DATAW = 32,
    parameter int IDXW  = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [IDXW-1:0]  pivot_col,
    input  logic [IDXW-1:0]  num_cols,
    input  logic [IDXW-1:0]  num_rows,
    input  logic [DATAW-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [DATAW-1:0] m_pivot,
    output logic [DATAW-1:0] m_rhs,
    output logic [IDXW-1:0]  m_row,
    output logic             m_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef POSITIVE_FILTER_EN
   ,output logic             m_eligible,
    output logic             unbounded
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  pc_q, last_col_q, last_row_q;
    logic [IDXW-1:0]  col_q, row_q;
    logic [DATAW-1:0] pivot_tmp;
    logic [IDXW:0]    pc_plus2;
    logic             start_legal, in_hs, out_hs, rhs_hs;
    logic             col_is_rhs, row_is_last;

    // Widened by one bit so pivot_col+2 cannot wrap when checked against num_cols.
    assign pc_plus2    = {1'b0, pivot_col} + (IDXW+1)'(2);
    assign start_legal = (pc_plus2 <= {1'b0, num_cols}) && (num_rows != '0);

    assign col_is_rhs  = (col_q == last_col_q);
    assign row_is_last = (row_q == last_row_q);

    assign s_ready = (state_q == S_STREAM) && (!col_is_rhs || !m_valid || m_ready);
    assign in_hs   = s_valid && s_ready;
    assign out_hs  = m_valid && m_ready;
    assign rhs_hs  = in_hs && col_is_rhs;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start && start_legal)  state_d = S_STREAM;
            S_STREAM: if (rhs_hs && row_is_last) state_d = S_DRAIN;
            S_DRAIN:  if (out_hs && m_last)      state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q       <= '0;
            last_col_q <= '0;
            last_row_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            pivot_tmp  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pc_q       <= pivot_col;
                        last_col_q <= num_cols - 1'b1;
                        last_row_q <= num_rows - 1'b1;
                        col_q      <= '0;
                        row_q      <= '0;
                        busy       <= start_legal;
                        err        <= !start_legal;
                    end
                end
                S_STREAM: begin
                    if (in_hs) begin
                        if (col_q == pc_q) pivot_tmp <= s_data;
                        if (col_is_rhs) begin
                            col_q <= '0;
                            if (!row_is_last) row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_hs && m_last) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output register: a capture in the same cycle as a handshake overrides the clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_pivot <= '0;
            m_rhs   <= '0;
            m_row   <= '0;
            m_last  <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            if (out_hs) m_valid <= 1'b0;
            if (rhs_hs) begin
                m_pivot <= pivot_tmp;
                m_rhs   <= s_data;
                m_row   <= row_q;
                m_last  <= row_is_last;
                m_valid <= 1'b1;
            end
        end
    end

`ifdef POSITIVE_FILTER_EN
    logic pivot_pos, any_elig;

    assign pivot_pos = !pivot_tmp[DATAW-1] && (pivot_tmp[DATAW-2:0] != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_eligible <= 1'b0;
            any_elig   <= 1'b0;
            unbounded  <= 1'b0;
        end else begin
            unbounded <= 1'b0;
            if (state_q == S_IDLE && start) any_elig <= 1'b0;
            if (rhs_hs) begin
                m_eligible <= pivot_pos;
                if (pivot_pos) any_elig <= 1'b1;
            end
            if (state_q == S_DRAIN && out_hs && m_last) unbounded <= !any_elig;
        end
    end
`endif

endmodule
